// File: rtl/haz_pkg.sv
// rtl/haz_pkg.sv - shared types for the multi-cycle hazard unit
//
// Purpose: FSM state encoding and forward-select encoding used by
// haz_unit_mc and haz_fwd.
// Ports: none (package).
package haz_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MEMW = 2'd1,
    MDIV = 2'd2
  } haz_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/haz_unit_mc_if.sv
// rtl/haz_unit_mc_if.sv - pipeline-to-hazard-unit signal bundle
//
// Purpose: groups every pipeline-side signal of haz_unit_mc.
// Modports:
//   master - core side: drives register indices, enables, handshakes;
//            receives stall/flush/forward controls and status.
//   slave  - hazard unit side (the reverse directions).
interface haz_unit_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) ();

  logic [REG_AW-1:0] rs1_d, rs2_d;
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
  logic [REG_AW-1:0] rd_m, rd_w;
  logic              regwrite_m, regwrite_w;
  logic [1:0]        resultsrc_e;
  logic              pcsrc;
  logic              mdiv_start_e;
  logic              mdiv_done;
  logic              dmem_req_m;
  logic              dmem_ready;

  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_m, flush_w;
  logic [1:0]        forwarda, forwardb;
  logic              busy;
  logic              err_timeout;
  logic [CNT_W-1:0]  perf_stall_cnt, perf_flush_cnt;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           regwrite_m, regwrite_w, resultsrc_e, pcsrc,
           mdiv_start_e, mdiv_done, dmem_req_m, dmem_ready,
    input  stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_m, flush_w,
           forwarda, forwardb, busy, err_timeout,
           perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           regwrite_m, regwrite_w, resultsrc_e, pcsrc,
           mdiv_start_e, mdiv_done, dmem_req_m, dmem_ready,
    output stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_m, flush_w,
           forwarda, forwardb, busy, err_timeout,
           perf_stall_cnt, perf_flush_cnt
  );

endinterface

// File: rtl/haz_fwd.sv
// rtl/haz_fwd.sv - single-operand M/W forwarding select
//
// Purpose: picks the freshest producer for one E-stage source operand.
// Ports:
//   i_rs                       E-stage source register index
//   i_rd_m, i_rd_w             M/W destination indices
//   i_regwrite_m, i_regwrite_w M/W write enables
//   o_fwd                      FWD_M, FWD_W or FWD_RF
module haz_fwd
  import haz_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rd_m,
  input  logic [REG_AW-1:0] i_rd_w,
  input  logic              i_regwrite_m,
  input  logic              i_regwrite_w,
  output fwd_sel_e          o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    // x0 is hardwired zero and must never be forwarded; M is younger than W.
    if (i_rs != '0) begin
      if (i_regwrite_m && (i_rs == i_rd_m))      o_fwd = FWD_M;
      else if (i_regwrite_w && (i_rs == i_rd_w)) o_fwd = FWD_W;
    end
  end

endmodule

// File: rtl/haz_unit_mc.sv
// rtl/haz_unit_mc.sv - stateful hazard unit with mul/div and dmem stalls
//
// Purpose: forwarding, load-use stall, branch flush, multi-cycle execute
// stall with watchdog, and data-memory back-pressure stall.
// Ports:
//   clk, rst  core clock, asynchronous active-high reset
//   hz        haz_unit_mc_if.slave: pipeline indices/handshakes in,
//             stall/flush/forward controls, busy, err_timeout,
//             perf counters out
// Optional feature: define HAZ_PERF_EN to build the saturating
// stall/flush performance counters; otherwise they read as zero.
module haz_unit_mc
  import haz_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int MDIV_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic           clk,
  input  logic           rst,
  haz_unit_mc_if.slave   hz
);

  localparam int WD_W = $clog2(MDIV_TIMEOUT) + 1;

  haz_state_e      r_state, w_next;
  logic [WD_W-1:0] r_wd;
  logic            r_err;

  fwd_sel_e w_fwda, w_fwdb;
  logic     w_lwstall, w_memwait;
  logic     w_run_eval, w_wd_clr, w_wd_inc, w_timeout;
  logic     w_stall_f, w_stall_d, w_stall_e, w_stall_m;
  logic     w_flush_d, w_flush_e, w_flush_m, w_flush_w;
  logic     w_unused_ok;

  haz_fwd #(.REG_AW(REG_AW)) u_fwd_a (
    .i_rs(hz.rs1_e), .i_rd_m(hz.rd_m), .i_rd_w(hz.rd_w),
    .i_regwrite_m(hz.regwrite_m), .i_regwrite_w(hz.regwrite_w),
    .o_fwd(w_fwda)
  );

  haz_fwd #(.REG_AW(REG_AW)) u_fwd_b (
    .i_rs(hz.rs2_e), .i_rd_m(hz.rd_m), .i_rd_w(hz.rd_w),
    .i_regwrite_m(hz.regwrite_m), .i_regwrite_w(hz.regwrite_w),
    .o_fwd(w_fwdb)
  );

  assign w_lwstall = hz.resultsrc_e[0] && (hz.rd_e != '0) &&
                     ((hz.rs1_d == hz.rd_e) || (hz.rs2_d == hz.rd_e));
  assign w_memwait = hz.dmem_req_m && !hz.dmem_ready;
  assign w_unused_ok = hz.resultsrc_e[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_wd_clr)      r_wd <= '0;
      else if (w_wd_inc) r_wd <= r_wd + WD_W'(1);
      if (w_timeout)     r_err <= 1'b1;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_run_eval = 1'b0;
    w_wd_clr   = 1'b0;
    w_wd_inc   = 1'b0;
    w_timeout  = 1'b0;
    w_stall_f  = 1'b0;
    w_stall_d  = 1'b0;
    w_stall_e  = 1'b0;
    w_stall_m  = 1'b0;
    w_flush_d  = 1'b0;
    w_flush_e  = 1'b0;
    w_flush_m  = 1'b0;
    w_flush_w  = 1'b0;

    case (r_state)
      RUN:  w_run_eval = 1'b1;
      MEMW: begin
        // mdiv_done is deliberately not looked at here.
        if (w_memwait) begin
          {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
          w_flush_w = 1'b1;
        end else begin
          w_run_eval = 1'b1;
        end
      end
      MDIV: begin
        if (hz.mdiv_done) begin
          // E advances with the result; branch/load-use act normally.
          w_next    = RUN;
          w_stall_f = w_lwstall;
          w_stall_d = w_lwstall;
          w_flush_e = w_lwstall | hz.pcsrc;
          w_flush_d = hz.pcsrc;
        end else begin
          {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
          w_flush_m = 1'b1;
          w_wd_inc  = 1'b1;
          if (r_wd == WD_W'(MDIV_TIMEOUT - 1)) begin
            w_timeout = 1'b1;
            w_next    = RUN;
          end
        end
      end
      default: w_next = RUN;
    endcase

    // Shared RUN rules; MEMW reuses them on its release cycle so a pending
    // mul/div in E goes straight on to MDIV.
    if (w_run_eval) begin
      if (w_memwait) begin
        {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
        w_flush_w = 1'b1;
        w_next    = MEMW;
      end else if (hz.mdiv_start_e) begin
        {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
        w_flush_m = 1'b1;
        w_wd_clr  = 1'b1;
        w_next    = MDIV;
      end else begin
        w_stall_f = w_lwstall;
        w_stall_d = w_lwstall;
        w_flush_e = w_lwstall | hz.pcsrc;
        w_flush_d = hz.pcsrc;
        w_next    = RUN;
      end
    end
  end

  assign hz.stall_f     = w_stall_f;
  assign hz.stall_d     = w_stall_d;
  assign hz.stall_e     = w_stall_e;
  assign hz.stall_m     = w_stall_m;
  assign hz.flush_d     = w_flush_d;
  assign hz.flush_e     = w_flush_e;
  assign hz.flush_m     = w_flush_m;
  assign hz.flush_w     = w_flush_w;
  assign hz.forwarda    = w_fwda;
  assign hz.forwardb    = w_fwdb;
  assign hz.busy        = (r_state != RUN);
  assign hz.err_timeout = r_err;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_f && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_d && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hz.perf_stall_cnt = r_stall_cnt;
  assign hz.perf_flush_cnt = r_flush_cnt;
`else
  assign hz.perf_stall_cnt = '0;
  assign hz.perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_haz_unit_mc.sv
// tb/tb_haz_unit_mc.sv - scoreboard bench for haz_unit_mc
module tb_haz_unit_mc;
  import haz_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   exp_stall_cnt = 0;
  int   exp_flush_cnt = 0;

  typedef struct {
    string      tag;
    logic [13:0] v;
  } sb_t;
  sb_t sb_q[$];

  haz_unit_mc_if #(.REG_AW(5), .CNT_W(32)) hz ();

  haz_unit_mc #(.REG_AW(5), .MDIV_TIMEOUT(64), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
  );

  always #5 clk = ~clk;

  // output vector: {stall f,d,e,m, flush d,e,m,w, fwda, fwdb, busy, err}
  localparam logic [7:0] SF_NONE = 8'b0000_0000;
  localparam logic [7:0] SF_MEM  = 8'b1111_0001;
  localparam logic [7:0] SF_MDV  = 8'b1110_0010;
  localparam logic [7:0] SF_LW   = 8'b1100_0100;
  localparam logic [7:0] SF_BR   = 8'b0000_1100;

  function automatic logic [13:0] ev(input logic [7:0] sf, input logic [1:0] fa,
                                     input logic [1:0] fb, input logic busy,
                                     input logic err);
    return {sf, fa, fb, busy, err};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rs1_d = '0; hz.rs2_d = '0; hz.rs1_e = '0; hz.rs2_e = '0; hz.rd_e = '0;
    hz.rd_m = '0; hz.rd_w = '0; hz.regwrite_m = 1'b0; hz.regwrite_w = 1'b0;
    hz.resultsrc_e = 2'b00; hz.pcsrc = 1'b0; hz.mdiv_start_e = 1'b0;
    hz.mdiv_done = 1'b0; hz.dmem_req_m = 1'b0; hz.dmem_ready = 1'b0;
  endtask

  // Inputs are already applied; push the expectation, sample 1 ns later
  // (mid low phase), compare, then move to the next negedge.
  task automatic cyc(input string tag, input logic [13:0] exp);
    sb_t e, o;
    logic [13:0] got;
    e.tag = tag;
    e.v   = exp;
    sb_q.push_back(e);
    #1;
    got = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m,
           hz.flush_d, hz.flush_e, hz.flush_m, hz.flush_w,
           hz.forwarda, hz.forwardb, hz.busy, hz.err_timeout};
    o = sb_q.pop_front();
    check_eq(o.tag, 64'(got), 64'(o.v));
    if (rst) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      exp_stall_cnt += int'(o.v[13]);
      exp_flush_cnt += int'(o.v[9]);
    end
    @(negedge clk);
  endtask

  task automatic check_perf(input string tag);
`ifdef HAZ_PERF_EN
    check_eq({tag, "_stall"}, 64'(hz.perf_stall_cnt), 64'(exp_stall_cnt));
    check_eq({tag, "_flush"}, 64'(hz.perf_flush_cnt), 64'(exp_flush_cnt));
`else
    check_eq({tag, "_stall"}, 64'(hz.perf_stall_cnt), 64'd0);
    check_eq({tag, "_flush"}, 64'(hz.perf_flush_cnt), 64'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    cyc("reset", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    rst = 1'b0;
    cyc("idle", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

    // forwarding
    hz.rd_m = 5'd5; hz.regwrite_m = 1'b1; hz.rd_w = 5'd5; hz.regwrite_w = 1'b1;
    hz.rs1_e = 5'd5; hz.rs2_e = 5'd3;
    cyc("fwd_m", ev(SF_NONE, 2'b10, 2'b00, 1'b0, 1'b0));
    hz.rs1_e = 5'd0;
    cyc("fwd_x0", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    hz.regwrite_m = 1'b0; hz.rs1_e = 5'd5;
    cyc("fwd_w", ev(SF_NONE, 2'b01, 2'b00, 1'b0, 1'b0));
    hz.regwrite_m = 1'b1; hz.rd_m = 5'd6; hz.rs1_e = 5'd6; hz.rs2_e = 5'd5;
    cyc("fwd_ab", ev(SF_NONE, 2'b10, 2'b01, 1'b0, 1'b0));
    hz.regwrite_w = 1'b0;
    cyc("fwd_wen", ev(SF_NONE, 2'b10, 2'b00, 1'b0, 1'b0));
    clear_inputs();

    // load-use and branch
    hz.resultsrc_e = 2'b01; hz.rd_e = 5'd7; hz.rs2_d = 5'd7;
    cyc("lw_stall", ev(SF_LW, 2'b00, 2'b00, 1'b0, 1'b0));
    clear_inputs();
    cyc("lw_release", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    hz.resultsrc_e = 2'b01; hz.rd_e = 5'd0; hz.rs2_d = 5'd0;
    cyc("lw_x0", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    hz.resultsrc_e = 2'b10; hz.rd_e = 5'd7; hz.rs1_d = 5'd7;
    cyc("lw_notload", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    clear_inputs();
    hz.pcsrc = 1'b1;
    cyc("branch", ev(SF_BR, 2'b00, 2'b00, 1'b0, 1'b0));
    clear_inputs();

    // memory wait: 3 wait cycles, branch masked while E is frozen
    hz.dmem_req_m = 1'b1; hz.dmem_ready = 1'b0;
    cyc("memw_1", ev(SF_MEM, 2'b00, 2'b00, 1'b0, 1'b0));
    hz.pcsrc = 1'b1;
    cyc("memw_2", ev(SF_MEM, 2'b00, 2'b00, 1'b1, 1'b0));
    cyc("memw_3", ev(SF_MEM, 2'b00, 2'b00, 1'b1, 1'b0));
    hz.dmem_ready = 1'b1;
    cyc("memw_rel", ev(SF_BR, 2'b00, 2'b00, 1'b1, 1'b0));
    clear_inputs();
    cyc("memw_run", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

    // mul/div: entry + 10 MDIV cycles stalled, done on the 11th
    hz.mdiv_start_e = 1'b1;
    cyc("mdiv_entry", ev(SF_MDV, 2'b00, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++)
      cyc($sformatf("mdiv_wait%0d", i), ev(SF_MDV, 2'b00, 2'b00, 1'b1, 1'b0));
    hz.mdiv_done = 1'b1;
    cyc("mdiv_done", ev(SF_NONE, 2'b00, 2'b00, 1'b1, 1'b0));
    clear_inputs();
    cyc("mdiv_run", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));

    // watchdog with a branch pending in E
    hz.mdiv_start_e = 1'b1; hz.pcsrc = 1'b1;
    cyc("to_entry", ev(SF_MDV, 2'b00, 2'b00, 1'b0, 1'b0));
    hz.mdiv_start_e = 1'b0;
    for (int i = 0; i < 64; i++)
      cyc($sformatf("to_wait%0d", i), ev(SF_MDV, 2'b00, 2'b00, 1'b1, 1'b0));
    cyc("to_exit", ev(SF_BR, 2'b00, 2'b00, 1'b0, 1'b1));
    clear_inputs();
    cyc("to_sticky", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b1));
    check_perf("perf");

    // memwait beats mdiv_start; done in MEMW ignored; MDIV follows MEMW
    hz.dmem_req_m = 1'b1; hz.mdiv_start_e = 1'b1;
    cyc("both_1", ev(SF_MEM, 2'b00, 2'b00, 1'b0, 1'b1));
    hz.mdiv_done = 1'b1;
    cyc("both_done_ign", ev(SF_MEM, 2'b00, 2'b00, 1'b1, 1'b1));
    hz.mdiv_done = 1'b0; hz.dmem_ready = 1'b1;
    cyc("both_to_mdiv", ev(SF_MDV, 2'b00, 2'b00, 1'b1, 1'b1));
    hz.dmem_req_m = 1'b0; hz.dmem_ready = 1'b0;
    cyc("both_mdiv1", ev(SF_MDV, 2'b00, 2'b00, 1'b1, 1'b1));
    cyc("both_mdiv2", ev(SF_MDV, 2'b00, 2'b00, 1'b1, 1'b1));

    // asynchronous reset mid-MDIV, checked before the next clock edge
    rst = 1'b1;
    clear_inputs();
    cyc("rst_async", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    rst = 1'b0;
    cyc("rst_run", ev(SF_NONE, 2'b00, 2'b00, 1'b0, 1'b0));
    check_perf("perf_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
